// File: rtl/bus_arb_if.sv
// Bus-arbiter signal bundle: requester handshake, per-master buses, default
// master (CPU) bus and the muxed slave-side bus.
interface bus_arb_if #(
  parameter int NM = 2,
  parameter int AW = 32
);
  logic [NM-1:0]    bus_req;
  logic [NM-1:0]    bus_lock;
  logic [NM-1:0]    bus_grant;
  logic [NM*AW-1:0] addr_m;
  logic [NM-1:0]    we_m;
  logic [NM*32-1:0] wd_m;
  logic [NM*2-1:0]  size_m;
  logic [AW-1:0]    addr_d;
  logic             we_d;
  logic [31:0]      wd_d;
  logic [1:0]       size_d;
  logic             stall_d;
  logic [AW-1:0]    addr_s;
  logic             we_s;
  logic [31:0]      wd_s;
  logic [1:0]       size_s;
  logic [31:0]      rd_s;
  logic [31:0]      rd_m;

  // Arbiter side: responds to the handshake and drives the slave bus.
  modport slave (
    input  bus_req, bus_lock, addr_m, we_m, wd_m, size_m,
           addr_d, we_d, wd_d, size_d, rd_s,
    output bus_grant, stall_d, addr_s, we_s, wd_s, size_s, rd_m
  );

  // Requester / CPU / slave-environment side.
  modport master (
    output bus_req, bus_lock, addr_m, we_m, wd_m, size_m,
           addr_d, we_d, wd_d, size_d, rd_s,
    input  bus_grant, stall_d, addr_s, we_s, wd_s, size_s, rd_m
  );
endinterface

// File: rtl/bus_arb.sv
// Round-robin bus arbiter with lock, plus master-to-slave bus multiplexer.
// The CPU owns the bus whenever no requesting master does.
module bus_arb #(
  parameter int NM = 2,
  parameter int AW = 32
) (
  input  logic     clk,
  input  logic     rstn,
  bus_arb_if.slave bus
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE_s, OWN_s} state_t;

  state_t        state, state_nx;
  logic [OW-1:0] owner, owner_nx;
  logic [OW-1:0] last, last_nx;
  logic [NM-1:0] grant, grant_nx;
  logic          own_bus;

  // Nearest requester after 'from', wrapping; walking from far to near lets
  // the closest hit overwrite earlier ones.
  function automatic logic [OW-1:0] rr_pick(input logic [NM-1:0] req,
                                            input logic [OW-1:0] from);
    logic [OW-1:0] sel;
    int            c;
    sel = from;
    for (int i = NM; i >= 1; i--) begin
      c = (int'(from) + i) % NM;
      if (req[c]) sel = OW'(c);
    end
    return sel;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE_s;
      owner <= '0;
      last  <= OW'(NM - 1);
      grant <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      grant <= grant_nx;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    grant_nx = grant;
    unique case (state)
      IDLE_s: begin
        grant_nx = '0;
        if (|bus.bus_req) begin
          state_nx = OWN_s;
          owner_nx = rr_pick(bus.bus_req, last);
          last_nx  = owner_nx;
          grant_nx = NM'(1) << owner_nx;
        end
      end
      OWN_s: begin
        // Other masters are ignored here, even in the release cycle.
        if (!(bus.bus_req[owner] | bus.bus_lock[owner])) begin
          state_nx = IDLE_s;
          grant_nx = '0;
        end
      end
      default: state_nx = IDLE_s;
    endcase
  end

  // Held in reset, the CPU bus is routed regardless of the stale state.
  assign own_bus = (state == OWN_s) && !rstn;

  always_comb begin
    bus.addr_s = bus.addr_d;
    bus.we_s   = bus.we_d;
    bus.wd_s   = bus.wd_d;
    bus.size_s = bus.size_d;
    if (own_bus) begin
      bus.addr_s = bus.addr_m[int'(owner)*AW +: AW];
      bus.we_s   = bus.we_m[owner];
      bus.wd_s   = bus.wd_m[int'(owner)*32 +: 32];
      bus.size_s = bus.size_m[int'(owner)*2 +: 2];
    end
  end

  assign bus.bus_grant = grant;
  assign bus.stall_d   = own_bus;
  assign bus.rd_m      = bus.rd_s;

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb: a 2-master instance for the main
// scenarios and a 4-master instance for round-robin ordering from 'last'.
module tb_bus_arb;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic rst4 = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_arb_if #(.NM(2), .AW(32)) bif ();
  bus_arb_if #(.NM(4), .AW(16)) bif4 ();

  bus_arb #(.NM(2), .AW(32)) dut  (.clk(clk), .rstn(rstn), .bus(bif));
  bus_arb #(.NM(4), .AW(16)) dut4 (.clk(clk), .rstn(rst4), .bus(bif4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Alternating-ownership table: req per cycle, grant and we_s after the edge.
  logic [1:0] alt_req   [11] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00};
  logic [1:0] alt_grant [11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
  logic       alt_we    [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bif.addr_d  = 32'h100;
    bif.we_d    = 1'b1;
    bif.wd_d    = 32'hCAFE0000;
    bif.size_d  = 2'd2;
    bif.addr_m  = {32'h2000, 32'h1000};
    bif.we_m    = 2'b00;
    bif.wd_m    = {32'h11111111, 32'h00000000};
    bif.size_m  = {2'd1, 2'd0};
    bif.rd_s    = 32'hDEADBEEF;
    bif.bus_req = 2'b11;
    bif.bus_lock = 2'b00;

    bif4.addr_d   = 16'h0D00;
    bif4.we_d     = 1'b0;
    bif4.wd_d     = 32'h0;
    bif4.size_d   = 2'd0;
    bif4.addr_m   = {16'h4333, 16'h4222, 16'h4111, 16'h4000};
    bif4.we_m     = 4'b0000;
    bif4.wd_m     = '0;
    bif4.size_m   = '0;
    bif4.rd_s     = 32'h0;
    bif4.bus_req  = 4'b0000;
    bif4.bus_lock = 4'b0000;

    // Reset held with both masters requesting.
    tick();
    tick();
    check("rst_addr_s", 64'(bif.addr_s), 64'h100);
    check("rst_grant", 64'(bif.bus_grant), 64'h0);
    check("rst_stall", 64'(bif.stall_d), 64'h0);
    rstn = 1'b0;
    rst4 = 1'b0;
    #1;
    check("post_rst_grant", 64'(bif.bus_grant), 64'h0);
    check("post_rst_addr_s", 64'(bif.addr_s), 64'h100);
    tick();
    check("first_grant", 64'(bif.bus_grant), 64'h1);
    check("first_stall", 64'(bif.stall_d), 64'h1);
    check("first_addr_s", 64'(bif.addr_s), 64'h1000);
    check("first_we_s", 64'(bif.we_s), 64'h0);
    check("first_wd_s", 64'(bif.wd_s), 64'h0);
    check("rd_m", 64'(bif.rd_m), 64'hDEADBEEF);
    bif.bus_req = 2'b00;
    tick();
    check("rel0_grant", 64'(bif.bus_grant), 64'h0);

    // DMA pattern on master 1: req+lock for one cycle, then lock only.
    bif.bus_req  = 2'b10;
    bif.bus_lock = 2'b10;
    tick();
    check("dma_grant", 64'(bif.bus_grant), 64'h2);
    check("dma_wd_s", 64'(bif.wd_s), 64'h11111111);
    check("dma_size_s", 64'(bif.size_s), 64'h1);
    bif.bus_req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      bif.addr_m[63:32] = (i % 2 == 0) ? 32'h3000 : 32'h2000;
      #1;
      check("dma_addr_s", 64'(bif.addr_s), (i % 2 == 0) ? 64'h3000 : 64'h2000);
      tick();
      check("dma_hold_grant", 64'(bif.bus_grant), 64'h2);
    end
    bif.bus_lock = 2'b00;
    tick();
    check("dma_rel_grant", 64'(bif.bus_grant), 64'h0);
    check("dma_rel_addr_s", 64'(bif.addr_s), 64'h100);

    // Two masters requesting continuously, each releasing after 3 cycles.
    for (int i = 0; i < 11; i++) begin
      bif.bus_req = alt_req[i];
      tick();
      check("alt_grant", 64'(bif.bus_grant), 64'(alt_grant[i]));
      check("alt_we_s", 64'(bif.we_s), 64'(alt_we[i]));
    end

    // No pre-emption of master 1 by a locking master 0.
    bif.bus_req = 2'b10;
    tick();
    check("np_grant", 64'(bif.bus_grant), 64'h2);
    bif.bus_req  = 2'b11;
    bif.bus_lock = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("np_hold", 64'(bif.bus_grant), 64'h2);
    end
    bif.bus_req = 2'b01;
    tick();
    check("np_release", 64'(bif.bus_grant), 64'h0);
    tick();
    check("np_next_grant", 64'(bif.bus_grant), 64'h1);
    check("np_next_addr_s", 64'(bif.addr_s), 64'h1000);

    // Reset pulse while master 0 owns the bus.
    rstn = 1'b1;
    tick();
    check("rp_grant", 64'(bif.bus_grant), 64'h0);
    check("rp_stall", 64'(bif.stall_d), 64'h0);
    check("rp_addr_s", 64'(bif.addr_s), 64'h100);
    rstn = 1'b0;
    tick();
    check("rp_regrant", 64'(bif.bus_grant), 64'h1);
    bif.bus_req  = 2'b00;
    bif.bus_lock = 2'b00;
    tick();
    check("rp_release", 64'(bif.bus_grant), 64'h0);

    // Four masters: make master 1 the last owner, then requests on 1 and 3.
    bif4.bus_req = 4'b0010;
    tick();
    check("nm4_setup_grant", 64'(bif4.bus_grant), 64'h2);
    bif4.bus_req = 4'b0000;
    tick();
    check("nm4_setup_rel", 64'(bif4.bus_grant), 64'h0);
    bif4.bus_req = 4'b1010;
    tick();
    check("nm4_grant3", 64'(bif4.bus_grant), 64'h8);
    check("nm4_addr3", 64'(bif4.addr_s), 64'h4333);
    bif4.bus_req = 4'b0010;
    tick();
    check("nm4_rel3", 64'(bif4.bus_grant), 64'h0);
    check("nm4_idle_addr", 64'(bif4.addr_s), 64'h0D00);
    tick();
    check("nm4_grant1", 64'(bif4.bus_grant), 64'h2);
    check("nm4_addr1", 64'(bif4.addr_s), 64'h4111);
    bif4.bus_req = 4'b0000;
    tick();
    check("nm4_rel1", 64'(bif4.bus_grant), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
